// File: rtl/mtl_touch_pkg.sv
// Shared definitions for the MTL touch-IC emulator: register map, device address,
// responder FSM states and the captured touch sample.
package mtl_touch_pkg;

  localparam logic [7:0] REG_GESTURE = 8'h00;
  localparam logic [7:0] REG_COUNT   = 8'h01;
  localparam logic [7:0] REG_X1H     = 8'h02;
  localparam logic [7:0] REG_X1L     = 8'h03;
  localparam logic [7:0] REG_Y1H     = 8'h04;
  localparam logic [7:0] REG_Y1L     = 8'h05;
  localparam logic [7:0] REG_X2H     = 8'h06;
  localparam logic [7:0] REG_X2L     = 8'h07;
  localparam logic [7:0] REG_Y2H     = 8'h08;
  localparam logic [7:0] REG_Y2L     = 8'h09;
  localparam logic [7:0] REG_LAST    = 8'h09;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h38;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StIgnore
  } i2c_rsp_state_t;

  typedef struct packed {
    logic [7:0] gesture;
    logic [3:0] count;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
  } touch_sample_t;

  // Register-map view of a sample; anything past the last register reads zero.
  function automatic logic [7:0] reg_read(input touch_sample_t s, input logic [7:0] addr);
    logic [7:0] d;
    d = 8'h00;
    if (addr <= REG_LAST) begin
      case (addr)
        REG_GESTURE: d = s.gesture;
        REG_COUNT:   d = {4'b0, s.count};
        REG_X1H:     d = {6'b0, s.x1[9:8]};
        REG_X1L:     d = s.x1[7:0];
        REG_Y1H:     d = {7'b0, s.y1[8]};
        REG_Y1L:     d = s.y1[7:0];
        REG_X2H:     d = {6'b0, s.x2[9:8]};
        REG_X2L:     d = s.x2[7:0];
        REG_Y2H:     d = {7'b0, s.y2[8]};
        REG_Y2L:     d = s.y2[7:0];
        default:     d = 8'h00;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronizes SCL/SDA and produces single-cycle SCL edge,
// START and STOP pulses from the synchronized/delayed pair.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_s;

  // Two-flop synchronizers plus one delay stage; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  // SDA may only move while SCL is high for bus conditions, so SCL must be high on both samples.
  assign start    = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop     = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/mtl_touch_emulator.sv
// MTL touch-IC stand-in: I2C read responder with a shadow register map, a pending
// sample buffer for loads arriving mid-transaction, and an active-low data-ready line.
module mtl_touch_emulator
  import mtl_touch_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int unsigned CLK_HZ   = 50_000_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iLOAD,
  input  logic [9:0] iX1,
  input  logic [9:0] iX2,
  input  logic [8:0] iY1,
  input  logic [8:0] iY2,
  input  logic [3:0] iTOUCH_COUNT,
  input  logic [7:0] iGESTURE,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       INT_n,
  output logic       oBUSY
);

  // Edge detection needs ~40 iCLK per SCL period; below 4 MHz even 100 kHz cannot work.
  if (CLK_HZ < 4_000_000) begin : g_clk_check
    $error("CLK_HZ too low for a 100 kHz SCL");
  end

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_monitor u_mon (
    .clk      (iCLK),
    .rst      (iRST),
    .scl      (I2C_SCLK),
    .sda      (I2C_SDAT),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_rsp_state_t state_q, state_d;
  logic [7:0]     shift_q, ptr_q;
  logic [3:0]     bit_cnt_q;
  logic           first_q, ack_q, busy_q, int_n_q;
  logic           sda_low_q, sda_low_d;
  touch_sample_t  shadow_q, pend_q, sample_in;
  logic           pend_valid_q;
  logic [7:0]     rd_data;
  logic           addr_match, byte_done;

  assign sample_in  = '{gesture: iGESTURE, count: iTOUCH_COUNT, x1: iX1, y1: iY1,
                        x2: iX2, y2: iY2};
  assign rd_data    = reg_read(shadow_q, ptr_q);
  assign addr_match = (shift_q[7:1] == DEV_ADDR);
  assign byte_done  = scl_fall && (bit_cnt_q == 4'd8);

  // Reset gates the driver directly so SDA is released the moment iRST rises.
  assign I2C_SDAT = (sda_low_q && !iRST) ? 1'b0 : 1'bz;
  assign INT_n    = int_n_q;
  assign oBUSY    = busy_q;

  // FSM state register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state; bus conditions override everything.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else if (start) begin
      state_d = StAddr;
    end else begin
      case (state_q)
        StAddr:    if (byte_done) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck: if (scl_fall) state_d = shift_q[0] ? StRdByte : StWrByte;
        StWrByte:  if (byte_done) state_d = StWrAck;
        StWrAck:   if (scl_fall) state_d = StWrByte;
        StRdByte:  if (byte_done) state_d = StRdAck;
        StRdAck:   if (scl_fall) state_d = ack_q ? StRdByte : StIgnore;
        default:   state_d = state_q;
      endcase
    end
  end

  // FSM output: next SDA pull-down, changed only on SCL falls (or released on bus conditions).
  always_comb begin
    sda_low_d = sda_low_q;
    if (start || stop) begin
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        StAddr:    if (byte_done) sda_low_d = addr_match;
        StAddrAck: if (scl_fall) sda_low_d = shift_q[0] & ~rd_data[7];
        StWrByte:  if (byte_done) sda_low_d = 1'b1;
        StWrAck:   if (scl_fall) sda_low_d = 1'b0;
        StRdByte:  if (scl_fall) sda_low_d = (bit_cnt_q == 4'd8) ? 1'b0 : ~shift_q[6];
        StRdAck:   if (scl_fall) sda_low_d = ack_q & ~rd_data[7];
        default:   sda_low_d = 1'b0;
      endcase
    end
  end

  // Shift register, bit counter, register pointer, busy flag and SDA driver.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 8'h00;
      first_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      sda_low_q <= sda_low_d;
      if (stop) busy_q <= 1'b0;
      else if (state_q == StAddr && state_d == StAddrAck) busy_q <= 1'b1;

      if (start) begin
        bit_cnt_q <= 4'd0;
        first_q   <= 1'b1;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (shift_q[0]) shift_q <= rd_data;
            end
          end
          StWrByte: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done && first_q) begin
              // Only the first written byte is a pointer; later bytes are acked and dropped.
              ptr_q   <= shift_q;
              first_q <= 1'b0;
            end
          end
          StWrAck: if (scl_fall) bit_cnt_q <= 4'd0;
          StRdByte: begin
            if (scl_rise) bit_cnt_q <= bit_cnt_q + 4'd1;
            else if (scl_fall && bit_cnt_q != 4'd8) shift_q <= {shift_q[6:0], 1'b0};
          end
          StRdAck: begin
            if (scl_rise) begin
              ack_q <= ~sda_s;
              if (!sda_s) ptr_q <= ptr_q + 8'd1;
            end else if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              shift_q   <= rd_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sample capture, pending buffer and interrupt; a new sample beats the read-clear.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      int_n_q      <= 1'b1;
    end else begin
      if (state_q == StRdAck && scl_rise && ptr_q == REG_COUNT) int_n_q <= 1'b1;
      if (iLOAD && (!busy_q || stop)) begin
        shadow_q     <= sample_in;
        pend_valid_q <= 1'b0;
        int_n_q      <= 1'b0;
      end else if (iLOAD) begin
        pend_q       <= sample_in;
        pend_valid_q <= 1'b1;
      end else if (stop && pend_valid_q) begin
        shadow_q     <= pend_q;
        pend_valid_q <= 1'b0;
        int_n_q      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtl_touch_emulator.sv
// Directed bench for mtl_touch_emulator: bit-banged I2C master, hand-computed register values.
`timescale 1ns/1ps
module tb_mtl_touch_emulator;

  localparam int Q = 400;  // quarter SCL period in ns (SCL = 625 kHz)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [9:0] x1 = '0, x2 = '0;
  logic [8:0] y1 = '0, y2 = '0;
  logic [3:0] cnt = '0;
  logic [7:0] gest = '0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       int_n, busy;
  logic       drove_low;
  int         tests = 0;
  int         fails = 0;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  mtl_touch_emulator #(.DEV_ADDR(7'h38), .CLK_HZ(50_000_000)) dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iLOAD        (load),
    .iX1          (x1),
    .iX2          (x2),
    .iY1          (y1),
    .iY2          (y2),
    .iTOUCH_COUNT (cnt),
    .iGESTURE     (gest),
    .I2C_SCLK     (scl),
    .I2C_SDAT     (sda),
    .INT_n        (int_n),
    .oBUSY        (busy)
  );

  task automatic do_load(input logic [9:0] ax1, input logic [8:0] ay1, input logic [9:0] ax2,
                         input logic [8:0] ay2, input logic [3:0] acnt, input logic [7:0] ag);
    @(negedge clk);
    x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; cnt = acnt; gest = ag;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic bus_start();
    m_low = 1'b0; #(Q);
    scl = 1'b1;   #(Q);
    m_low = 1'b1; #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    m_low = 1'b0; #(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = !b; #(Q);
    scl = 1'b1; #(Q);
    if (b && sda !== 1'b1) drove_low = 1'b1;
    #(Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #(Q);
    scl = 1'b1;   #(Q);
    b = sda;      #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(!ack);
  endtask

  task automatic test_reset();
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL reset_int_n: got %b want 1", int_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b want 1", sda); end
  endtask

  task automatic test_read_map();
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp [4];
    exp[0] = 8'h02; exp[1] = 8'hA5; exp[2] = 8'h01; exp[3] = 8'hC3;
    do_load(10'h2A5, 9'h1C3, 10'h155, 9'h0AA, 4'd1, 8'h10);
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL load_int_n: got %b want 0", int_n); end
    bus_start();
    write_byte(8'h70, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL map_addr_ack: got %b want 1", ack); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL map_busy: got %b want 1", busy); end
    write_byte(8'h02, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL map_ptr_ack: got %b want 1", ack); end
    bus_start();
    write_byte(8'h71, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL map_raddr_ack: got %b want 1", ack); end
    for (int i = 0; i < 4; i++) begin
      read_byte(i != 3, d);
      tests++;
      if (d !== exp[i]) begin
        fails++; $display("FAIL map_byte%0d: got %h want %h", i, d, exp[i]);
      end
    end
    bus_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL map_busy_end: got %b want 0", busy); end
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL map_int_kept: got %b want 0", int_n); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    drove_low = 1'b0;
    bus_start();
    write_byte(8'h72, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL badaddr_ack: got %b want 0", ack); end
    tests++; if (drove_low !== 1'b0) begin fails++; $display("FAIL badaddr_drive: got %b want 0", drove_low); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badaddr_busy: got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic test_int_clear();
    logic       ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h70, ack);
    write_byte(8'h00, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL intclr_ptr_ack: got %b want 1", ack); end
    bus_start();
    write_byte(8'h71, ack);
    read_byte(1'b1, d);
    tests++; if (d !== 8'h10) begin fails++; $display("FAIL intclr_gesture: got %h want 10", d); end
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL intclr_early: got %b want 0", int_n); end
    read_byte(1'b0, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL intclr_count: got %h want 01", d); end
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL intclr_int_n: got %b want 1", int_n); end
    bus_stop();
  endtask

  task automatic test_load_while_busy();
    logic       ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h70, ack);
    write_byte(8'h01, ack);
    bus_start();
    write_byte(8'h71, ack);
    do_load(10'h3FF, 9'h1FF, 10'h001, 9'h002, 4'd2, 8'h33);
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL pend_int_early: got %b want 1", int_n); end
    read_byte(1'b0, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL pend_old_count: got %h want 01", d); end
    bus_stop();
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL pend_int_applied: got %b want 0", int_n); end
    bus_start();
    write_byte(8'h70, ack);
    write_byte(8'h01, ack);
    bus_start();
    write_byte(8'h71, ack);
    read_byte(1'b0, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL pend_new_count: got %h want 02", d); end
    bus_stop();
  endtask

  task automatic test_ptr_wrap();
    logic       ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h70, ack);
    write_byte(8'hFF, ack);
    bus_start();
    write_byte(8'h71, ack);
    read_byte(1'b1, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL wrap_ff: got %h want 00", d); end
    read_byte(1'b0, d);
    tests++; if (d !== 8'h33) begin fails++; $display("FAIL wrap_00: got %h want 33", d); end
    bus_stop();
  endtask

  task automatic test_reset_mid();
    logic       ack, b;
    logic [7:0] d;
    logic [7:0] a;
    a = 8'h70;
    do_load(10'h000, 9'h000, 10'h000, 9'h000, 4'd3, 8'h5A);
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL rstmid_int_pre: got %b want 0", int_n); end
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    m_low = 1'b0;
    @(negedge clk);
    tests++; if (sda !== 1'b0) begin fails++; $display("FAIL rstmid_ack_driven: got %b want 0", sda); end
    rst = 1'b1;
    #1;
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL rstmid_sda: got %b want 1", sda); end
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL rstmid_int_n: got %b want 1", int_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    read_bit(b);
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL rstmid_ignored: got %b want 1", b); end
    bus_stop();
    bus_start();
    write_byte(8'h70, ack);
    write_byte(8'h01, ack);
    bus_start();
    write_byte(8'h71, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rstmid_reack: got %b want 1", ack); end
    read_byte(1'b0, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL rstmid_cleared: got %h want 00", d); end
    bus_stop();
  endtask

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_map();
    test_wrong_addr();
    test_int_clear();
    test_load_while_busy();
    test_ptr_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mtl_touch_emulator.md
# mtl_touch_emulator

I2C responder that stands in for the MTL touch IC on the I2C bus, letting the existing touch-controller path run on the DE0-Nano without the MTL panel attached. It captures a touch sample from on-board sources (switches, test pattern, or a bench) into a shadow register map, signals new data on an active-low interrupt, and serves register reads with pointer auto-increment. It connects to the same SDA/SCL/INT_n nets the touch controller drives and monitors.

## Interface
- DEV_ADDR, 7'h38, 7-bit I2C device address answered.
- CLK_HZ, 50_000_000, iCLK frequency; used only for the documented SCL limit.
- iCLK  in  1  system clock, 50 MHz.
- iRST  in  1  asynchronous, active-high reset.
- iLOAD  in  1  one-cycle strobe: capture the sample inputs.
- iX1, iX2  in  10  touch point 1/2 X coordinate.
- iY1, iY2  in  9  touch point 1/2 Y coordinate.
- iTOUCH_COUNT  in  4  number of touches (0..5).
- iGESTURE  in  8  gesture code.
- I2C_SCLK  in  1  I2C clock (responder never stretches).
- I2C_SDAT  inout  1  I2C data; driven 0 or Z only, never 1.
- INT_n  out  1  data-ready interrupt, active low.
- oBUSY  out  1  high from addressed START until STOP.

## Operation
- SCL/SDA pass through 2-flop synchronizers; edges from the registered pair. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Register map (8-bit): 0x00 gesture; 0x01 {4'b0,touch_count}; 0x02 {6'b0,X1[9:8]}; 0x03 X1[7:0]; 0x04 {7'b0,Y1[8]}; 0x05 Y1[7:0]; 0x06..0x09 same for point 2. Addresses 0x0A..0xFF read 0x00.
- Capture: iLOAD copies all inputs into shadow registers and sets INT_n=0. If iLOAD arrives while oBUSY=1, inputs are latched into a pending buffer, applied on STOP (newest iLOAD wins). INT_n falls at application time.
- INT_n returns to 1 once byte 0x01 has been shifted out and the master's ACK/NACK bit sampled.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- IDLE -> ADDR on START. START in any state (repeated START) -> ADDR; STOP in any state -> IDLE.
- ADDR: shift 8 bits MSB first on SCL rise. Address match -> ADDR_ACK. Mismatch -> IGNORE (no SDA drive until STOP/START).
- ADDR_ACK: drive SDA=0 for the ninth clock. Then R/W=0 -> WR_BYTE; R/W=1 -> RD_BYTE loading shadow[ptr].
- WR_BYTE: first byte after address sets ptr; further bytes ACKed and discarded. WR_ACK drives ACK, returns to WR_BYTE.
- RD_BYTE: present bit on SDA (Z for 1, 0 for 0) after each SCL fall. RD_ACK: release SDA, sample master bit on SCL rise. ACK -> ptr+1, reload, RD_BYTE. NACK -> IGNORE.
- ptr is 8-bit, wraps 0xFF->0x00; persists across transactions; reset 0x00.

## Timing
- Reset values: INT_n=1, oBUSY=0, SDA released (Z), state IDLE, ptr=0x00, shadow and pending all zero, no pending flag.
- SDA output change occurs ≤4 iCLK after the SCL falling edge at the pins (2 sync + 1 edge + 1 register); never on SCL high.
- Requires SCL ≤ CLK_HZ/40 (1.25 MHz at 50 MHz); 100/400 kHz supported.
- iLOAD with oBUSY=0: shadow updated and INT_n=0 on the next iCLK edge.
- iLOAD and STOP in the same cycle: iLOAD data wins over older pending data; applied that cycle.
- iRST mid-transaction: SDA released immediately (asynchronous), FSM to IDLE; the following bus traffic is ignored until the next START.
- oBUSY rises in the ADDR_ACK entry cycle, falls on STOP detection.

## Structure
- Package mtl_touch_pkg: register address constants (REG_GESTURE..REG_Y2L, REG_LAST=8'h09), default DEV_ADDR, FSM state enum i2c_rsp_state_t.
- Sub-module i2c_bus_monitor: synchronizers plus SCL rise/fall, START, STOP pulses; reused by any future I2C block.
- Top contains the FSM, shift register, bit counter (0..8), ptr, shadow/pending banks.

## Test plan
- Load X1=0x2A5, Y1=0x1C3, count=1, gesture=0x10; write ptr 0x02, repeated START, read 4 bytes -> 0x02,0xA5,0x01,0xC3; ACKs on address and pointer.
- Address 0x39 with DEV_ADDR=0x38 -> SDA never driven low through the full byte, ninth bit reads 1 (NACK).
- iLOAD -> INT_n=0; read from ptr 0x00 two bytes -> INT_n=1 after second byte's ACK bit.
- iLOAD (count=2) during an active read of ptr 0x01 -> current byte returns old count; after STOP, new read returns 0x02, INT_n low again.
- Write ptr 0xFF, read 2 bytes -> 0x00 then gesture value (ptr wrap).
- Assert iRST while responder drives ACK low -> SDA released within the same cycle; INT_n=1, oBUSY=0.
